// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction
// fetch and the memory stage. Each access walks IDLE -> ISSUE -> (WAIT) -> DONE,
// so only one transaction is ever outstanding. Data wins ties, bounded by a
// streak counter so fetch cannot starve. A flush (i_kill) suppresses a fetch
// completion without aborting the RAM read. All outputs are registered.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_kill,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  localparam logic [2:0]    LAT  = 3'(READ_LATENCY);

  state_t            state_q, state_d;
  logic              own_d_q, own_d_d;     // 1 = data port owns the FSM
  logic              we_q, we_d;
  logic [2:0]        lat_q, lat_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              kill_q, kill_d;
  logic              i_ack_q, i_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic fetch_ok, streak_full, grant_d, grant_i, kill_now;

  // Next-state, arbitration and registered-output computation
  always_comb begin
    state_d     = state_q;
    own_d_d     = own_d_q;
    we_d        = we_q;
    lat_d       = lat_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    i_ack_d     = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    // A killed fetch never competes; streak_full hands the tie to fetch.
    fetch_ok    = i_req && !i_kill;
    streak_full = (MAX_D_STREAK != 0) && (streak_q == SMAX);
    grant_d     = d_req && !(fetch_ok && streak_full);
    grant_i     = fetch_ok && !grant_d;
    // Kill in the capture cycle itself must also suppress the ack.
    kill_now    = kill_q || i_kill;

    case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (grant_d) begin
          own_d_d     = 1'b1;
          we_d        = d_we;
          mem_en_d    = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!i_req)                streak_d = '0;
          else if (streak_q != SMAX) streak_d = streak_q + 1'b1;
          state_d     = S_ISSUE;
        end else if (grant_i) begin
          // Fetch leaves mem_wdata at its last value; it is never written.
          own_d_d    = 1'b0;
          we_d       = 1'b0;
          mem_en_d   = 1'b1;
          mem_addr_d = i_addr;
          streak_d   = '0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!own_d_q && i_kill) kill_d = 1'b1;
        lat_d = LAT;
        if (we_q) begin
          d_ack_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!own_d_q && i_kill) kill_d = 1'b1;
        if (lat_q == 3'd1) begin
          if (own_d_q) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else if (!kill_now) begin
            i_rdata_d = mem_rdata;
            i_ack_d   = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - 3'd1;
        end
      end
      S_DONE: begin
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      own_d_q     <= 1'b0;
      we_q        <= 1'b0;
      lat_q       <= '0;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      i_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_d_q     <= own_d_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      i_ack_q     <= i_ack_d;
      i_rdata_q   <= i_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_ack     = i_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT a uses default parameters, DUT b uses READ_LATENCY=3.
// Each has its own RAM model with the matching read latency.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tb_init = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic        a_i_req = 0, a_i_kill = 0, a_d_req = 0, a_d_we = 0;
  logic [9:0]  a_i_addr = 0, a_d_addr = 0;
  logic [31:0] a_d_wdata = 0;
  logic        a_i_ack, a_d_ack, a_mem_en, a_mem_we;
  logic [31:0] a_i_rdata, a_d_rdata, a_mem_wdata;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_rdata;

  logic        b_i_req = 0, b_i_kill = 0, b_d_req = 0, b_d_we = 0;
  logic [9:0]  b_i_addr = 0, b_d_addr = 0;
  logic [31:0] b_d_wdata = 0;
  logic        b_i_ack, b_d_ack, b_mem_en, b_mem_we;
  logic [31:0] b_i_rdata, b_d_rdata, b_mem_wdata;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_rdata;

  mem_port_arbiter u_dut_a (
    .clk(clk), .rst(rst),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_kill(a_i_kill),
    .i_ack(a_i_ack), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_ack(a_d_ack), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.READ_LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_kill(b_i_kill),
    .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Initial RAM image: a few named words, otherwise an address pattern
  function automatic logic [31:0] ram_init(input logic [9:0] a);
    case (a)
      10'h010: ram_init = 32'h00500093;
      10'h030: ram_init = 32'h11111111;
      10'h040: ram_init = 32'h22222222;
      10'h033: ram_init = 32'hCAFEF00D;
      default: ram_init = {a, a, 12'h5A5};
    endcase
  endfunction

  logic [31:0] ram_a [1024];
  logic [31:0] ram_b [1024];
  logic [31:0] b_p1, b_p2;

  // RAM a: one-cycle read latency
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) ram_a[i] <= ram_init(10'(i));
    end else if (a_mem_en) begin
      if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
      else          a_mem_rdata <= ram_a[a_mem_addr];
    end
  end

  // RAM b: three-cycle read latency
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) ram_b[i] <= ram_init(10'(i));
    end else begin
      if (b_mem_en && b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
      if (b_mem_en && !b_mem_we) b_p1 <= ram_b[b_mem_addr];
      b_p2 <= b_p1;
      b_mem_rdata <= b_p2;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_i_req = 0; a_i_kill = 0; a_d_req = 0; a_d_we = 0;
    b_d_req = 0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Runs one data transaction on DUT a; cycle 0 is the IDLE cycle it is sampled in
  task automatic run_d(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                       output int lat, output logic [31:0] rd, output int wec);
    tick;
    a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wd;
    lat = -1; wec = 0; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (a_mem_we) wec++;
      if (a_d_ack) begin
        lat = c;
        rd = a_d_rdata;
        break;
      end
    end
    a_d_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++;
    if ({a_i_ack, a_d_ack, a_mem_en, a_mem_we} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {a_i_ack, a_d_ack, a_mem_en, a_mem_we});
    end
    total++;
    if ({a_mem_addr, a_mem_wdata, a_i_rdata, a_d_rdata} !== '0) begin
      bad++; $display("FAIL reset_data addr=%h wdata=%h ir=%h dr=%h want all 0",
                      a_mem_addr, a_mem_wdata, a_i_rdata, a_d_rdata);
    end
    tb_init = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_fetch;
    a_i_req = 1'b1; a_i_addr = 10'h010;
    for (int c = 1; c <= 6; c++) begin
      tick;
      total++;
      if (a_mem_en !== (c == 1)) begin
        bad++; $display("FAIL fetch_mem_en c=%0d got=%b want=%b", c, a_mem_en, c == 1);
      end
      total++;
      if (a_i_ack !== (c == 3)) begin
        bad++; $display("FAIL fetch_ack c=%0d got=%b want=%b", c, a_i_ack, c == 3);
      end
      if (c == 1) begin
        total++;
        if (a_mem_addr !== 10'h010 || a_mem_we !== 1'b0) begin
          bad++; $display("FAIL fetch_addr got=%h we=%b want=010 we=0", a_mem_addr, a_mem_we);
        end
      end
      if (c == 3) begin
        total++;
        if (a_i_rdata !== 32'h00500093) begin
          bad++; $display("FAIL fetch_rdata got=%h want=00500093", a_i_rdata);
        end
        a_i_req = 1'b0;
      end
    end
  endtask

  task automatic test_store_load;
    int lat, wec;
    logic [31:0] rd;
    run_d(1'b1, 10'h020, 32'hDEADBEEF, lat, rd, wec);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL store_lat got=%0d want=2", lat); end
    total++;
    if (wec !== 1) begin bad++; $display("FAIL store_we_cycles got=%0d want=1", wec); end
    run_d(1'b0, 10'h020, 32'h0, lat, rd, wec);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL load_lat got=%0d want=3", lat); end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata got=%h want=deadbeef", rd); end
    total++;
    if (wec !== 0) begin bad++; $display("FAIL load_we_cycles got=%0d want=0", wec); end
  endtask

  task automatic test_streak;
    logic [9:0] exp_ord;
    logic [9:0] got;
    int n;
    exp_ord = 10'b1000010000;   // bit k = 1 for a fetch grant, k = 0 first
    got = '0;
    n = 0;
    do_reset;
    a_i_addr = 10'h100; a_d_addr = 10'h200; a_d_we = 1'b0;
    a_i_req = 1'b1; a_d_req = 1'b1;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick;
      if (a_mem_en) begin
        got[n] = (a_mem_addr == 10'h100);
        n++;
      end
    end
    a_i_req = 1'b0; a_d_req = 1'b0;
    total++;
    if (n !== 10) begin bad++; $display("FAIL streak_count got=%0d want=10", n); end
    for (int k = 0; k < 10; k++) begin
      total++;
      if (got[k] !== exp_ord[k]) begin
        bad++; $display("FAIL streak_grant k=%0d got_fetch=%b want_fetch=%b", k, got[k], exp_ord[k]);
      end
    end
    repeat (6) tick;
  endtask

  task automatic test_kill;
    int acks;
    acks = 0;
    do_reset;
    a_i_req = 1'b1; a_i_addr = 10'h030;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (a_i_ack) break;
    end
    a_i_req = 1'b0;
    total++;
    if (a_i_rdata !== 32'h11111111) begin
      bad++; $display("FAIL kill_pre_rdata got=%h want=11111111", a_i_rdata);
    end
    tick;
    a_i_req = 1'b1; a_i_addr = 10'h040;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (a_i_ack) acks++;
      if (c == 2) begin
        a_i_kill = 1'b1; a_i_req = 1'b0;
        a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 10'h050;
      end
      if (c == 3) a_i_kill = 1'b0;
      if (c == 5) begin
        total++;
        if (a_mem_en !== 1'b1 || a_mem_addr !== 10'h050) begin
          bad++; $display("FAIL kill_d_grant en=%b addr=%h want en=1 addr=050", a_mem_en, a_mem_addr);
        end
      end
      if (c == 7) begin
        total++;
        if (a_d_ack !== 1'b1 || a_d_rdata !== ram_init(10'h050)) begin
          bad++; $display("FAIL kill_d_ack ack=%b data=%h want ack=1 data=%h",
                          a_d_ack, a_d_rdata, ram_init(10'h050));
        end
        a_d_req = 1'b0;
      end
    end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL kill_no_ack got=%0d want=0", acks); end
    total++;
    if (a_i_rdata !== 32'h11111111) begin
      bad++; $display("FAIL kill_rdata_held got=%h want=11111111", a_i_rdata);
    end
  endtask

  task automatic test_latency3;
    int ack_c, acks, en_c;
    logic [31:0] rd;
    ack_c = -1; acks = 0; en_c = -1; rd = '0;
    tick;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 10'h033;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (b_mem_en && en_c < 0) en_c = c;
      if (b_d_ack) begin
        acks++;
        if (ack_c < 0) begin ack_c = c; rd = b_d_rdata; end
        b_d_req = 1'b0;
      end
    end
    total++;
    if (en_c !== 1) begin bad++; $display("FAIL lat3_en got=%0d want=1", en_c); end
    total++;
    if (ack_c !== 5) begin bad++; $display("FAIL lat3_ack_cycle got=%0d want=5", ack_c); end
    total++;
    if (acks !== 1) begin bad++; $display("FAIL lat3_ack_count got=%0d want=1", acks); end
    total++;
    if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL lat3_rdata got=%h want=cafef00d", rd); end
  endtask

  task automatic test_async_reset;
    int acks, ack_c;
    acks = 0; ack_c = -1;
    tick;
    a_i_req = 1'b1; a_i_addr = 10'h010;
    tick; tick;                 // now in WAIT
    #3;
    rst = 1'b1;
    a_i_req = 1'b0;
    #1;
    total++;
    if ({a_i_ack, a_d_ack, a_mem_en, a_mem_we} !== 4'b0 ||
        {a_mem_addr, a_mem_wdata, a_i_rdata, a_d_rdata} !== '0) begin
      bad++; $display("FAIL async_reset ctl=%b addr=%h ir=%h dr=%h want all 0",
                      {a_i_ack, a_d_ack, a_mem_en, a_mem_we}, a_mem_addr, a_i_rdata, a_d_rdata);
    end
    tick;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (a_i_ack) acks++;
    end
    total++;
    if (acks !== 0) begin bad++; $display("FAIL async_no_ack got=%0d want=0", acks); end
    a_i_req = 1'b1; a_i_addr = 10'h040;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (a_i_ack) begin ack_c = c; break; end
    end
    a_i_req = 1'b0;
    total++;
    if (ack_c !== 3 || a_i_rdata !== 32'h22222222) begin
      bad++; $display("FAIL async_refetch cycle=%0d data=%h want cycle=3 data=22222222", ack_c, a_i_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store_load;
    test_streak;
    test_kill;
    test_latency3;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction RAM between the fetch stage (instruction reads) and the memory stage (LW/SW from the MemRead/MemWrite control bits).
- Sequences each access through a registered request/issue/wait/complete FSM.
- Data requests take priority so the memory stage can drain, with an anti-starvation guard that bounds how long fetch can wait.
- Fetch results can be killed on a taken-branch flush.

Parameters:
ADDR_W, 10, word-address width of the shared RAM
DATA_W, 32, data width
READ_LATENCY, 1, cycles from mem_en to valid mem_rdata (1..4)
MAX_D_STREAK, 4, consecutive data grants allowed while i_req is pending; 0 = strict data priority

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
i_req  in  1  fetch read request; held until i_ack
i_addr  in  ADDR_W  fetch word address; stable while i_req
i_kill  in  1  flush: drop any pending or in-flight fetch response
i_ack  out  1  one-cycle fetch completion pulse
i_rdata  out  DATA_W  fetch data; valid with i_ack, held until next fetch ack
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data; valid with d_ack
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- All outputs are registered. Reset (async, any time) does the following:
  - state=IDLE; all acks, mem_en and mem_we=0; addr, wdata and rdata outputs=0; streak counter=0.
  - An in-flight transaction is abandoned with no ack. A store already issued may have completed in RAM.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any request is present (fetch requests with i_kill=1 are ignored), grant one owner. Latch owner, we, addr and wdata. Go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): mem_en=1. mem_we=latched we (fetch always 0). mem_addr and mem_wdata come from the latch. A store goes to DONE. A load or fetch goes to WAIT with lat_cnt=READ_LATENCY.
  - WAIT: lat_cnt decrements each cycle. When it reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
  - DONE (1 cycle): the owner's ack=1. Requests are ignored in this cycle. Next state is IDLE.
- Timing from a request sampled in IDLE at cycle T:
  - mem_en at T+1.
  - Store ack at T+2.
  - Load or fetch ack at T+2+READ_LATENCY (T+3 at default).
- A requester may keep req high after its ack to start a new transaction; it is sampled in IDLE, the cycle after DONE.
- Arbitration in IDLE:
  - Only one request present: that requester wins.
  - Both present: data wins, unless MAX_D_STREAK≠0 and streak==MAX_D_STREAK, in which case fetch wins.
  - Streak counter: +1 on a data grant while i_req=1 (saturating at MAX_D_STREAK). Cleared on a fetch grant, or on a data grant while i_req=0.
- Kill:
  - i_kill=1 in any cycle while fetch owns the FSM (ISSUE/WAIT/DONE-pending) sets a kill flag. At completion, i_ack stays 0 and i_rdata is not updated. The FSM still runs to DONE and IDLE normally; the RAM read is not aborted.
  - i_kill in IDLE blocks the fetch grant that cycle.
  - The kill flag clears on entering IDLE.
  - i_kill has no effect on data transactions.
- Only one transaction is ever outstanding. mem_en is high for exactly one cycle per transaction.
- The mem_* signals are 0 when not in ISSUE. mem_addr and mem_wdata hold their last value.

Test Plan:
- Reset, then i_req=1, i_addr=0x010, RAM[0x010]=0x00500093 -> mem_en at cycle 1 with addr 0x010; i_ack=1 with i_rdata=0x00500093 at cycle 3; i_ack=0 in every other cycle.
- d_req=1, d_we=1, d_addr=0x020, d_wdata=0xDEADBEEF, then a load from 0x020 -> store ack at cycle 2, mem_we=1 for exactly one cycle; load d_rdata=0xDEADBEEF.
- i_req and d_req held high continuously with MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; fetch waits at most 4 data transactions.
- Fetch granted, then i_kill=1 during WAIT -> no i_ack pulse, i_rdata unchanged; a following data request is granted on the first IDLE cycle.
- READ_LATENCY=3, a single load -> ack exactly 5 cycles after the request is sampled; rdata matches RAM.
- rst asserted asynchronously mid-WAIT -> all outputs 0 immediately; no ack after release; a new request completes normally.
